fetch_sequencer: RTL

- Control block that sequences the instruction fetch stage of the RV32 pipeline.
- Owns the fetch PC and issues one instruction-memory request at a time over a req/gnt/rvalid handshake.
- Applies branch redirects arriving from MEM and discards stale responses.
- Holds fetched instructions in an output register plus a one-entry skid buffer while decode stalls, driving the IF/ID interface.

---
 rtl/fetch_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, keeps one imem request in flight,
// and feeds the IF/ID register through a one-entry skid buffer while decode stalls.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_mem_if,
  input  logic [31:0] PC_branch_mem_if,
  input  logic        stall_id,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_if_id,
  output logic [31:0] PC_if_id,
  output logic        valid_if_id
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

  state_t      r_state, w_stateNext;
  logic [31:0] r_pc, w_pcNext;
  logic [31:0] r_pcReq, w_pcReqNext;
  logic [31:0] r_instr, w_instrNext;
  logic [31:0] r_pcOut, w_pcOutNext;
  logic [31:0] r_skidInstr, w_skidInstrNext;
  logic [31:0] r_skidPc, w_skidPcNext;
  logic        r_valid, w_validNext;
  logic        w_outFree;
  logic        w_unusedTargetBits;

  // The request is masked while reset is held because the reset state is already REQ.
  assign imem_req           = rst && (r_state == REQ);
  assign imem_addr          = r_pc;
  assign instr_if_id        = r_instr;
  assign PC_if_id           = r_pcOut;
  assign valid_if_id        = r_valid;
  assign w_outFree          = !r_valid || !stall_id;
  assign w_unusedTargetBits = ^PC_branch_mem_if[1:0];

  always_comb begin
    w_stateNext     = r_state;
    w_pcNext        = r_pc;
    w_pcReqNext     = r_pcReq;
    w_instrNext     = r_instr;
    w_pcOutNext     = r_pcOut;
    w_skidInstrNext = r_skidInstr;
    w_skidPcNext    = r_skidPc;
    w_validNext     = r_valid;

    if (r_valid && !stall_id) begin
      w_validNext = 1'b0;
      w_instrNext = NOP_INSTR;
    end

    if (branch_mem_if) begin
      // Redirect wins; a fetch granted or still in flight must have its response dropped.
      w_pcNext    = {PC_branch_mem_if[31:2], 2'b00};
      w_validNext = 1'b0;
      w_instrNext = NOP_INSTR;
      case (r_state)
        REQ:     w_stateNext = imem_gnt ? DROP : REQ;
        WAIT:    w_stateNext = imem_rvalid ? REQ : DROP;
        HOLD:    w_stateNext = REQ;
        DROP:    w_stateNext = imem_rvalid ? REQ : DROP;
        default: w_stateNext = REQ;
      endcase
    end else begin
      case (r_state)
        REQ: begin
          if (imem_gnt) begin
            w_pcReqNext = r_pc;
            w_pcNext    = r_pc + 32'd4;
            w_stateNext = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (w_outFree) begin
              w_instrNext = imem_rdata;
              w_pcOutNext = r_pcReq;
              w_validNext = 1'b1;
              w_stateNext = REQ;
            end else begin
              w_skidInstrNext = imem_rdata;
              w_skidPcNext    = r_pcReq;
              w_stateNext     = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_id) begin
            w_instrNext = r_skidInstr;
            w_pcOutNext = r_skidPc;
            w_validNext = 1'b1;
            w_stateNext = REQ;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            w_stateNext = REQ;
          end
        end
        default: w_stateNext = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= REQ;
      r_pc        <= RESET_PC;
      r_pcReq     <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_pcOut     <= 32'h0;
      r_skidInstr <= NOP_INSTR;
      r_skidPc    <= 32'h0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_pc        <= w_pcNext;
      r_pcReq     <= w_pcReqNext;
      r_instr     <= w_instrNext;
      r_pcOut     <= w_pcOutNext;
      r_skidInstr <= w_skidInstrNext;
      r_skidPc    <= w_skidPcNext;
      r_valid     <= w_validNext;
    end
  end

endmodule
